// File: rtl/wb_mem_pkg.sv
// Shared types and helpers for the Wishbone memory responder.
// Holds the FSM state encoding, the byte-lane count and the word-index arithmetic.
package wb_mem_pkg;

    localparam int WB_DATA_W = 32;
    localparam int WB_SEL_W  = WB_DATA_W / 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } wb_state_e;

    // The subtraction wraps at the bus width, so an address below the base
    // lands far above any RAM depth instead of aliasing into it.
    function automatic logic [63:0] wb_word_index(input logic [63:0] addr,
                                                  input logic [63:0] base,
                                                  input int          aw);
        logic [63:0] mask;
        logic [63:0] diff;
        mask = (aw >= 64) ? '1 : ((64'd1 << aw) - 64'd1);
        diff = (addr - base) & mask;
        return diff >> 2;
    endfunction

endpackage

// File: rtl/wb_mem_responder_if.sv
// Wishbone-classic bus between a core port and its memory responder.
// The master drives the request; the slave returns data with an ack or err pulse.
interface wb_mem_responder_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    logic                      cyc_i;
    logic                      stb_i;
    logic                      we_i;
    logic [ADDR_WIDTH-1:0]     addr_i;
    logic [DATA_WIDTH-1:0]     data_i;
    logic [DATA_WIDTH/8-1:0]   sel_i;
    logic [DATA_WIDTH-1:0]     data_o;
    logic                      ack_o;
    logic                      err_o;

    modport master (
        output cyc_i, stb_i, we_i, addr_i, data_i, sel_i,
        input  data_o, ack_o, err_o
    );

    modport slave (
        input  cyc_i, stb_i, we_i, addr_i, data_i, sel_i,
        output data_o, ack_o, err_o
    );
endinterface

// File: rtl/wb_mem_ram.sv
// Single-port word RAM with per-byte write enables and a registered read port.
// Latency: read data valid one cycle after en_i; no backpressure, accepts every enabled cycle.
module wb_mem_ram
    import wb_mem_pkg::*;
#(
    parameter int MEM_WORDS  = 4096,
    parameter int DATA_WIDTH = 32,
    parameter int IDX_W      = 12
) (
    input  logic                    clk,
    input  logic                    en_i,
    input  logic [WB_SEL_W-1:0]     be_i,
    input  logic [IDX_W-1:0]        addr_i,
    input  logic [DATA_WIDTH-1:0]   wdata_i,
    output logic [DATA_WIDTH-1:0]   rdata_o
);

    logic [DATA_WIDTH-1:0] mem_q [MEM_WORDS];
    logic [DATA_WIDTH-1:0] rdata_q;

    always_ff @(posedge clk) begin
        if (en_i) begin
            for (int b = 0; b < WB_SEL_W; b++) begin
                if (be_i[b]) begin
                    mem_q[addr_i][b*8 +: 8] <= wdata_i[b*8 +: 8];
                end
            end
            rdata_q <= mem_q[addr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/wb_mem_responder.sv
// Wishbone-classic memory responder with WAIT_STATES programmable wait cycles; WB_MEM_RESPONDER_RANGE_CHECK_EN turns out-of-range accesses into err.
// Latency: ack/err WAIT_STATES+1 cycles after accept; stalls the master via delayed ack, one idle cycle between transfers.
module wb_mem_responder
    import wb_mem_pkg::*;
#(
    parameter int                    ADDR_WIDTH  = 32,
    parameter int                    DATA_WIDTH  = 32,
    parameter int                    MEM_WORDS   = 4096,
    parameter int                    WAIT_STATES = 1,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR   = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    wb_mem_responder_if.slave bus
);

    localparam int IDX_W = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;

`ifdef WB_MEM_RESPONDER_RANGE_CHECK_EN
    localparam bit RANGE_CHECK = 1'b1;
`else
    localparam bit RANGE_CHECK = 1'b0;
`endif

    wb_state_e             state_q, state_d;
    logic [3:0]            cnt_q, cnt_d;
    logic                  we_q;
    logic [IDX_W-1:0]      idx_q;
    logic [DATA_WIDTH-1:0] wdat_q;
    logic [WB_SEL_W-1:0]   sel_q;
    logic                  oob_q;

    logic                  req;
    logic                  go_resp;
    logic [IDX_W-1:0]      req_idx;
    logic                  req_oob;

    logic                  cur_we;
    logic [IDX_W-1:0]      cur_idx;
    logic [DATA_WIDTH-1:0] cur_wdat;
    logic [WB_SEL_W-1:0]   cur_sel;
    logic                  cur_oob;
    logic                  ram_en;
    logic [WB_SEL_W-1:0]   ram_be;
    logic [DATA_WIDTH-1:0] ram_rdat;

    assign req     = bus.cyc_i & bus.stb_i;
    assign req_idx = IDX_W'(wb_word_index(64'(bus.addr_i), 64'(BASE_ADDR), ADDR_WIDTH));
    assign req_oob = RANGE_CHECK &&
                     (wb_word_index(64'(bus.addr_i), 64'(BASE_ADDR), ADDR_WIDTH) >= 64'(MEM_WORDS));

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        go_resp = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (req) begin
                    if (WAIT_STATES == 0) begin
                        state_d = RESP;
                        go_resp = 1'b1;
                    end else begin
                        state_d = WAIT;
                        cnt_d   = 4'(WAIT_STATES - 1);
                    end
                end
            end
            WAIT: begin
                // A dropped cycle wins over an expiring counter: nothing commits.
                if (!bus.cyc_i) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == 4'd0) begin
                    state_d = RESP;
                    go_resp = 1'b1;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            we_q   <= 1'b0;
            idx_q  <= '0;
            wdat_q <= '0;
            sel_q  <= '0;
            oob_q  <= 1'b0;
        end else if (state_q == IDLE && req) begin
            we_q   <= bus.we_i;
            idx_q  <= req_idx;
            wdat_q <= bus.data_i;
            sel_q  <= bus.sel_i;
            oob_q  <= req_oob;
        end
    end

    // With no wait states the RAM access happens on the accept edge itself,
    // so the live bus feeds the RAM while idle and the latched copy otherwise.
    assign cur_we   = (state_q == IDLE) ? bus.we_i   : we_q;
    assign cur_idx  = (state_q == IDLE) ? req_idx    : idx_q;
    assign cur_wdat = (state_q == IDLE) ? bus.data_i : wdat_q;
    assign cur_sel  = (state_q == IDLE) ? bus.sel_i  : sel_q;
    assign cur_oob  = (state_q == IDLE) ? req_oob    : oob_q;

    assign ram_en = go_resp & ~cur_oob;
    assign ram_be = cur_we ? cur_sel : '0;

    wb_mem_ram #(
        .MEM_WORDS  (MEM_WORDS),
        .DATA_WIDTH (DATA_WIDTH),
        .IDX_W      (IDX_W)
    ) u_ram (
        .clk     (clk),
        .en_i    (ram_en),
        .be_i    (ram_be),
        .addr_i  (cur_idx),
        .wdata_i (cur_wdat),
        .rdata_o (ram_rdat)
    );

    assign bus.ack_o  = (state_q == RESP) & ~oob_q;
    assign bus.err_o  = RANGE_CHECK ? ((state_q == RESP) & oob_q) : 1'b0;
    assign bus.data_o = ((state_q == RESP) && !we_q && !oob_q) ? ram_rdat : '0;

endmodule
